uart_tx_shifter: RTL

Serial datapath of the UART transmitter. It sits directly downstream of the transmit controller FSM and consumes that FSM's `load` and `shift_en` strobes. It frames a parallel data word (start bit, data LSB first, optional parity, stop bits), paces bits with an internal baud divider, and drives the `tx` line. It returns the `done` pulse that the controller waits on in its SHIFT state.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_counter.sv | 42 ++++
 rtl/uart_tx_shifter.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and sizing helpers used by the transmit and receive paths.
package uart_pkg;

    localparam int unsigned PAR_NONE = 32'd0;
    localparam int unsigned PAR_EVEN = 32'd1;
    localparam int unsigned PAR_ODD  = 32'd2;

    // Frame length in bits: start + data + optional parity + stop bits.
    function automatic int unsigned frame_len(input int unsigned data_bits,
                                              input int unsigned parity,
                                              input int unsigned stop_bits);
        return 32'd1 + data_bits + ((parity != PAR_NONE) ? 32'd1 : 32'd0) + stop_bits;
    endfunction

    // Counter width able to hold values 0..n-1 (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time divider: counts enabled cycles and flags the last cycle of each bit period.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Terminal count only when this cycle actually counts; clear wins over counting.
    always_comb begin
        tc_c  = enable && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tc_c) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_shifter.sv
// UART transmit datapath: frames a word, paces bits via the baud divider and drives tx.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift_en,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned F   = frame_len(DATA_BITS, PARITY, STOP_BITS);
    localparam int unsigned BCW = cnt_width(F + 32'd1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(F - 32'd1);

    logic [F-1:0]   shreg_q;
    logic [F-1:0]   shreg_d;
    logic [F-1:0]   load_word;
    logic [BCW-1:0] bit_cnt_q;
    logic [BCW-1:0] bit_cnt_d;
    logic           busy_q;
    logic           busy_d;
    logic           done_q;
    logic           done_d;
    logic           parity_bit;
    logic           advance;
    logic           baud_tc;

    // The shift register LSB is the line itself; it is a flop, so tx is registered.
    assign tx   = shreg_q[0];
    assign busy = busy_q;
    assign done = done_q;

    // A load cycle never counts as a bit-time cycle.
    assign advance = busy_q && shift_en && !load;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (load),
        .enable (advance),
        .tc_c   (baud_tc)
    );

    // Build the frame image: stop ones above optional parity, data, then start bit.
    always_comb begin
        parity_bit = (PARITY == PAR_ODD) ? ~(^data_in) : (^data_in);
        load_word  = '1;
        load_word[DATA_BITS:1] = data_in;
        load_word[0] = 1'b0;
        if (PARITY != PAR_NONE) begin
            load_word[DATA_BITS+1] = parity_bit;
        end
    end

    // Next-state: load restarts the frame; each bit boundary shifts or ends the frame.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (load) begin
            shreg_d   = load_word;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
        end else if (baud_tc) begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bit_cnt_q < LAST_BIT) begin
                shreg_d = {1'b1, shreg_q[F-1:1]};
            end else begin
                // Last stop bit is already on the line (LSB is 1); leave it there.
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // State registers; reset leaves the line idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '1;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule
